// File: rtl/switch_debouncer.sv
// switch_debouncer
// Turns one raw, bouncing, asynchronous switch input into a clean registered
// level (sw_out) plus single-cycle rise/fall pulses. A new level is accepted
// only after the synchronized input has held it on DEBOUNCE_CYCLES+1
// consecutive edges. Short bounces are dropped without producing any pulse.

module switch_debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_WIDTH       = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_in,
   output logic sw_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   typedef enum logic [1:0] {
      STABLE_LOW,
      WAIT_HIGH,
      STABLE_HIGH,
      WAIT_LOW
   } state_t;

   // The count that marks the final edge of the stability window.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 s1;
   logic                 s2;
   logic                 sync;
   state_t               state;
   state_t               state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic                 sw_out_nxt;
   logic                 rise_nxt;
   logic                 fall_nxt;

   // Two-flop synchronizer that brings the asynchronous switch into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= sw_in;
         s2 <= s1;
      end
   end

   assign sync = s2;

   // Registers for the FSM state, the stability counter and all outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= STABLE_LOW;
         cnt        <= '0;
         sw_out     <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         sw_out     <= sw_out_nxt;
         rise_pulse <= rise_nxt;
         fall_pulse <= fall_nxt;
      end
   end

   // Next-state logic: enter WAIT on the first differing sample, then accept or reject.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      sw_out_nxt = sw_out;
      rise_nxt   = 1'b0;
      fall_nxt   = 1'b0;
      case (state)
         STABLE_LOW: begin
            if (sync) begin
               state_nxt = WAIT_HIGH;
               cnt_nxt   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!sync) begin
               state_nxt = STABLE_LOW;
            end else if (cnt == CNT_LAST) begin
               state_nxt  = STABLE_HIGH;
               sw_out_nxt = 1'b1;
               rise_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_WIDTH'(1);
            end
         end
         STABLE_HIGH: begin
            if (!sync) begin
               state_nxt = WAIT_LOW;
               cnt_nxt   = '0;
            end
         end
         WAIT_LOW: begin
            if (sync) begin
               state_nxt = STABLE_HIGH;
            end else if (cnt == CNT_LAST) begin
               state_nxt  = STABLE_LOW;
               sw_out_nxt = 1'b0;
               fall_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_WIDTH'(1);
            end
         end
         default: begin
            state_nxt = STABLE_LOW;
         end
      endcase
   end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Debounces and synchronizes one raw mechanical switch input into a clean, glitch-free level plus single-cycle edge pulses. It sits directly upstream of `inverter_switch`: `sw_out` drives that gate's `x` input, so the inverter only ever sees settled switch levels. It consists of a 2-flop synchronizer, a stability counter and a 4-state FSM, all in one clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive synchronized samples, after the first differing sample, needed to accept a new level (1 ms at 50 MHz). Legal range is 1 to 2^CNT_WIDTH-1.
- `CNT_WIDTH`, default 16: width of the stability counter.
- `clk  input  1`: single clock; all state updates on its rising edge.
- `rst  input  1`: asynchronous, active-high reset. It clears every flop immediately, with no clock edge needed.
- `sw_in  input  1`: raw switch level. It is asynchronous to `clk` and may bounce.
- `sw_out  output  1`: debounced level, registered. Feeds `inverter_switch.x`.
- `rise_pulse  output  1`: one-cycle pulse when `sw_out` goes 0→1.
- `fall_pulse  output  1`: one-cycle pulse when `sw_out` goes 1→0.

## Operation
- Synchronizer: `s1 <= sw_in`, then `s2 <= s1`. Only `s2` (call it `sync`) is used downstream.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. Reset state is STABLE_LOW.
- STABLE_LOW:
  - `sync`=1 → WAIT_HIGH, `cnt`<=0.
  - Otherwise stay.
- WAIT_HIGH:
  - `sync`=0 → STABLE_LOW. The glitch is rejected and no pulse is emitted.
  - `sync`=1 and `cnt`==DEBOUNCE_CYCLES-1 → STABLE_HIGH, `sw_out`<=1, `rise_pulse`<=1.
  - Otherwise `cnt`<=`cnt`+1.
- STABLE_HIGH and WAIT_LOW mirror the two states above with polarity inverted, using `fall_pulse`.
- Counter rules:
  - `cnt` is unsigned, CNT_WIDTH bits.
  - It is only advanced in WAIT states, so it never wraps.
  - It is cleared on every entry to a WAIT state.
- Pulse outputs:
  - Each pulse is high for exactly one cycle, on the same edge that updates `sw_out`; it is cleared on the next edge.
  - `rise_pulse` and `fall_pulse` are never high together.
- Reset values: `sw_out`=0, `rise_pulse`=0, `fall_pulse`=0, `s1`=`s2`=0, `cnt`=0, state STABLE_LOW.
- Reset with `sw_in`=1:
  - While `rst`=1, outputs stay 0.
  - After release, the block debounces up from 0 with full latency.
- Reset mid-operation: asserting `rst` in any state discards all pending progress. There are no pulses on reset entry or exit.

## Timing
- Acceptance condition: `sync` must equal the new level on DEBOUNCE_CYCLES+1 consecutive edges. The first of these edges is the one that enters WAIT.
- Latency for a raw change stable before edge 0:
  - `s2` changes at edge 1.
  - WAIT is entered at edge 2.
  - `sw_out` and the pulse register at edge DEBOUNCE_CYCLES+2.
- Glitch threshold: a raw pulse that covers DEBOUNCE_CYCLES or fewer sampling edges never changes `sw_out`. One that covers DEBOUNCE_CYCLES+1 edges is accepted.
- Back-to-back transitions: the minimum spacing between a rise pulse and a fall pulse is DEBOUNCE_CYCLES+1 cycles.
- `rst` deassertion is treated as synchronous to `clk` by the bench: release `rst` away from the rising edge.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_WIDTH=3, and count edges from the first rising edge after the stimulus change.
- Reset: `rst`=1 with `sw_in`=1 for 10 cycles → `sw_out`=0, `rise_pulse`=0 and `fall_pulse`=0 throughout, state STABLE_LOW.
- Clean press: `sw_in` 0→1, held 20 cycles → `sw_out`=1 at edge 6. `rise_pulse`=1 only in the cycle after edge 6, and `fall_pulse` stays 0.
- Bounce, rejected case: `sw_in` high 3 cycles, low 2, high 4, then low → `sw_out` stays 0 and no pulses occur.
- Bounce, accepted case: `sw_in` high exactly 5 cycles → `sw_out`=1 at edge 6, one `rise_pulse`.
- Release: from debounced high, `sw_in` 1→0 held → `sw_out`=0 at edge 6, `fall_pulse` one cycle, `rise_pulse` stays 0.
- Reset mid-WAIT: `sw_in`=1 for 4 cycles (FSM in WAIT_HIGH), then `rst` pulsed mid-cycle → all outputs 0 immediately, with no clock edge needed. With `sw_in` still 1, `sw_out`=1 at edge 6 after the first edge following release, with one `rise_pulse`.
